// File: rtl/pipe_hazard_unit_if.sv
// Hazard-unit signal bundle: the OF-stage instruction description and branch/perf
// controls flow in from the pipeline (master), and the interlock/forwarding controls
// flow back (slave = hazard unit).
interface pipe_hazard_unit_if #(
    parameter int REG_AW = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic              id_valid;
    logic [REG_AW-1:0] id_src1;
    logic              id_src1_used;
    logic [REG_AW-1:0] id_src2;
    logic              id_src2_used;
    logic [REG_AW-1:0] id_dst;
    logic              id_wb;
    logic              id_ld;
    logic              br_taken;
    logic              perf_clr;

    logic              stall;
    logic              bubble_ex;
    logic              flush;
    logic [SEL_W-1:0]  fwd_sel1;
    logic [SEL_W-1:0]  fwd_sel2;
    logic [SEL_W-1:0]  inflight_cnt;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output id_valid, id_src1, id_src1_used, id_src2, id_src2_used,
               id_dst, id_wb, id_ld, br_taken, perf_clr,
        input  stall, bubble_ex, flush, fwd_sel1, fwd_sel2, inflight_cnt, stall_cycles
    );

    modport slave (
        input  id_valid, id_src1, id_src1_used, id_src2, id_src2_used,
               id_dst, id_wb, id_ld, br_taken, perf_clr,
        output stall, bubble_ex, flush, fwd_sel1, fwd_sel2, inflight_cnt, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Interlock / forwarding controller for the IF/OF/EX/MA/RW pipeline.
// A shift scoreboard remembers the register writes issued after OF; the OF
// instruction's sources are compared against it to pick forwarding paths or
// to hold the front end. All control outputs are combinational from the OF
// inputs and the registered scoreboard.
module pipe_hazard_unit #(
    parameter int REG_AW = 4,
    parameter int DEPTH  = 4,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    pipe_hazard_unit_if.slave hz
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              v;
        logic              wb;
        logic              ld;
        logic [REG_AW-1:0] dst;
    } entry_t;

    // entReg[0] = EX, [1] = MA, [2] = RW, [3] = WB latch
    entry_t           entReg [DEPTH];
    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;
    logic [DEPTH-1:0] isWrite;
    logic [SEL_W-1:0] youngest1;
    logic [SEL_W-1:0] youngest2;
    logic [SEL_W-1:0] inflightSum;
    logic             hazard;
    logic             stallInt;
    logic [CNT_W-1:0] stallCntReg;

    // Per-entry source comparison; register 0 is compared like any other.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign isWrite[gi] = entReg[gi].v & entReg[gi].wb;
            assign match1[gi]  = hz.id_src1_used & isWrite[gi] & (entReg[gi].dst == hz.id_src1);
            assign match2[gi]  = hz.id_src2_used & isWrite[gi] & (entReg[gi].dst == hz.id_src2);
        end
    endgenerate

    // Youngest producer wins: scan oldest first so lower indices overwrite; also count live writes.
    always_comb begin
        youngest1   = '0;
        youngest2   = '0;
        inflightSum = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match1[k]) youngest1 = SEL_W'(k + 1);
            if (match2[k]) youngest2 = SEL_W'(k + 1);
            inflightSum = inflightSum + SEL_W'(isWrite[k]);
        end
    end

    // With forwarding only a load still in EX cannot supply its result; without it any RAW blocks.
    always_comb begin
        hazard = 1'b0;
        if (FWD_EN != 0) begin
            hazard = (match1[0] | match2[0]) & entReg[0].ld;
        end else begin
            hazard = (|match1) | (|match2);
        end
    end

    // A taken branch kills the OF instruction, so it never stalls at the same time.
    assign stallInt        = hz.id_valid & hazard & ~hz.br_taken;
    assign hz.stall        = stallInt;
    assign hz.bubble_ex    = stallInt;
    assign hz.flush        = hz.br_taken;
    assign hz.fwd_sel1     = ((FWD_EN != 0) && hz.id_valid) ? youngest1 : '0;
    assign hz.fwd_sel2     = ((FWD_EN != 0) && hz.id_valid) ? youngest2 : '0;
    assign hz.inflight_cnt = inflightSum;
    assign hz.stall_cycles = stallCntReg;

    // Scoreboard always advances; a stalled or flushed OF slot enters as a bubble.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                entReg[k] <= '0;
            end
        end else begin
            entReg[0] <= '{v:   hz.id_valid & ~stallInt & ~hz.br_taken,
                           wb:  hz.id_wb,
                           ld:  hz.id_ld,
                           dst: hz.id_dst};
            for (int k = 1; k < DEPTH; k++) begin
                entReg[k] <= entReg[k - 1];
            end
        end
    end

    // Saturating stall-cycle counter; a clear takes priority over counting.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stallCntReg <= '0;
        end else if (hz.perf_clr) begin
            stallCntReg <= '0;
        end else if (stallInt && (stallCntReg != '1)) begin
            stallCntReg <= stallCntReg + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: one forwarding instance (A) and one full-interlock
// instance with a 4-bit stall counter (B) share the same stimulus. Expected
// outputs are queued as each OF instruction is driven and compared mid-cycle.
module tb_pipe_hazard_unit;
    typedef struct packed {
        logic       stall;
        logic       bubble;
        logic       flush;
        logic [2:0] fwd1;
        logic [2:0] fwd2;
        logic [2:0] infl;
    } obs_t;

    typedef struct {
        logic       v;
        logic [3:0] s1;
        logic       u1;
        logic [3:0] s2;
        logic       u2;
        logic [3:0] d;
        logic       wb;
        logic       ld;
        logic       br;
        obs_t       e;
        logic [11:0] m;
    } row_t;

    localparam logic [11:0] ALL   = 12'hFFF;
    localparam logic [11:0] NOFWD = 12'hE07;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    int          checks = 0;
    int          errors = 0;
    obs_t        expQ[$];
    logic [11:0] maskQ[$];

    pipe_hazard_unit_if #(.REG_AW(4), .DEPTH(4), .CNT_W(16)) ifA();
    pipe_hazard_unit_if #(.REG_AW(4), .DEPTH(4), .CNT_W(4))  ifB();

    pipe_hazard_unit #(.REG_AW(4), .DEPTH(4), .FWD_EN(1), .CNT_W(16)) dutA (
        .clock(clock), .reset(reset), .hz(ifA)
    );
    pipe_hazard_unit #(.REG_AW(4), .DEPTH(4), .FWD_EN(0), .CNT_W(4)) dutB (
        .clock(clock), .reset(reset), .hz(ifB)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic row_t mk(logic v, logic [3:0] s1, logic u1, logic [3:0] s2, logic u2,
                                logic [3:0] d, logic wb, logic ld, logic br,
                                logic st, logic fl, logic [2:0] f1, logic [2:0] f2,
                                logic [2:0] inf, logic [11:0] m);
        row_t r;
        r.v = v; r.s1 = s1; r.u1 = u1; r.s2 = s2; r.u2 = u2;
        r.d = d; r.wb = wb; r.ld = ld; r.br = br;
        r.e = {st, st, fl, f1, f2, inf};
        r.m = m;
        return r;
    endfunction

    function automatic obs_t sample(bit useB);
        obs_t o;
        if (useB) o = {ifB.stall, ifB.bubble_ex, ifB.flush, ifB.fwd_sel1, ifB.fwd_sel2, ifB.inflight_cnt};
        else      o = {ifA.stall, ifA.bubble_ex, ifA.flush, ifA.fwd_sel1, ifA.fwd_sel2, ifA.inflight_cnt};
        return o;
    endfunction

    task automatic apply(row_t r);
        ifA.id_valid = r.v;      ifB.id_valid = r.v;
        ifA.id_src1 = r.s1;      ifB.id_src1 = r.s1;
        ifA.id_src1_used = r.u1; ifB.id_src1_used = r.u1;
        ifA.id_src2 = r.s2;      ifB.id_src2 = r.s2;
        ifA.id_src2_used = r.u2; ifB.id_src2_used = r.u2;
        ifA.id_dst = r.d;        ifB.id_dst = r.d;
        ifA.id_wb = r.wb;        ifB.id_wb = r.wb;
        ifA.id_ld = r.ld;        ifB.id_ld = r.ld;
        ifA.br_taken = r.br;     ifB.br_taken = r.br;
    endtask

    task automatic drive(row_t r);
        apply(r);
        expQ.push_back(r.e);
        maskQ.push_back(r.m);
    endtask

    task automatic setClr(logic c);
        ifA.perf_clr = c;
        ifB.perf_clr = c;
    endtask

    task automatic idle(int n, logic clr);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL));
        setClr(clr);
        repeat (n) @(posedge clock);
        #1;
        setClr(1'b0);
    endtask

    task automatic applyGarbage();
        apply(mk(1, 4'($urandom_range(15)), 1, 4'($urandom_range(15)), 1,
                 4'($urandom_range(15)), 1, 1, 0, 0, 0, 0, 0, 0, ALL));
    endtask

    task automatic test_reset();
        obs_t got;
        applyGarbage();
        setClr(1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            got = sample(0);
            checks++;
            if (got !== '0) begin errors++; $display("FAIL reset_outA[%0d] got=%h exp=000", c, got); end
            else $display("ok   reset_outA[%0d] got=%h", c, got);
            got = sample(1);
            checks++;
            if (got !== '0) begin errors++; $display("FAIL reset_outB[%0d] got=%h exp=000", c, got); end
            else $display("ok   reset_outB[%0d] got=%h", c, got);
            checks++;
            if (ifA.stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_cntA[%0d] got=%0d exp=0", c, ifA.stall_cycles); end
            else $display("ok   reset_cntA[%0d] got=0", c);
            checks++;
            if (ifB.stall_cycles !== 4'd0) begin errors++; $display("FAIL reset_cntB[%0d] got=%0d exp=0", c, ifB.stall_cycles); end
            else $display("ok   reset_cntB[%0d] got=0", c);
            @(posedge clock);
            #1;
            applyGarbage();
        end
        @(negedge clock);
        #2 reset = 1'b1;
    endtask

    task automatic test_forward();
        row_t rows[$];
        obs_t got, exp;
        logic [11:0] m;
        rows.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, ALL)); // add r3
        rows.push_back(mk(1, 3, 1, 3, 0, 4, 1, 0, 0, 0, 0, 1, 0, 1, ALL)); // r4<-r3 from EX, src2 unused
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, ALL)); // nop
        rows.push_back(mk(1, 3, 1, 4, 1, 7, 1, 0, 0, 0, 0, 3, 2, 2, ALL)); // r3 from RW, r4 from MA
        rows.push_back(mk(1, 3, 1, 4, 1, 3, 1, 0, 0, 0, 0, 4, 3, 3, ALL)); // r3 from WB latch
        rows.push_back(mk(1, 3, 1, 4, 1, 3, 1, 0, 0, 0, 0, 1, 4, 3, ALL)); // new r3 in EX
        rows.push_back(mk(1, 3, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 3, 3, ALL)); // two r3 writers: youngest
        rows.push_back(mk(0, 3, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, ALL)); // invalid OF: no forward
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clock);
            got = sample(0);
            exp = expQ.pop_front();
            m = maskQ.pop_front();
            checks++;
            if ((got & m) !== (exp & m)) begin errors++; $display("FAIL forward[%0d] got=%h exp=%h mask=%h", i, got, exp, m); end
            else $display("ok   forward[%0d] got=%h", i, got);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_load_use();
        row_t rows[$];
        obs_t got, exp;
        logic [11:0] m;
        rows.push_back(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, ALL));   // ld r5
        rows.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 1, 0, 0, 0, 1, NOFWD)); // use r5: stall
        rows.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 2, 0, 1, ALL));   // resolved from MA
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, ALL));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clock);
            got = sample(0);
            exp = expQ.pop_front();
            m = maskQ.pop_front();
            checks++;
            if ((got & m) !== (exp & m)) begin errors++; $display("FAIL load_use[%0d] got=%h exp=%h mask=%h", i, got, exp, m); end
            else $display("ok   load_use[%0d] got=%h", i, got);
            @(posedge clock);
            #1;
        end
        checks++;
        if (ifA.stall_cycles !== 16'd1) begin errors++; $display("FAIL load_use_cnt got=%0d exp=1", ifA.stall_cycles); end
        else $display("ok   load_use_cnt got=1");
    endtask

    task automatic test_interlock();
        row_t rows[$];
        obs_t got, exp;
        logic [11:0] m;
        rows.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, ALL)); // add r3
        repeat (4) rows.push_back(mk(1, 3, 1, 0, 0, 4, 1, 0, 0, 1, 0, 0, 0, 1, ALL));
        rows.push_back(mk(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, ALL)); // r3 retired
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ALL));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clock);
            got = sample(1);
            exp = expQ.pop_front();
            m = maskQ.pop_front();
            checks++;
            if ((got & m) !== (exp & m)) begin errors++; $display("FAIL interlock[%0d] got=%h exp=%h mask=%h", i, got, exp, m); end
            else $display("ok   interlock[%0d] got=%h", i, got);
            @(posedge clock);
            #1;
        end
        checks++;
        if (ifB.stall_cycles !== 4'd4) begin errors++; $display("FAIL interlock_cnt got=%0d exp=4", ifB.stall_cycles); end
        else $display("ok   interlock_cnt got=4");
    endtask

    task automatic test_flush();
        row_t rows[$];
        obs_t got, exp;
        logic [11:0] m;
        rows.push_back(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, ALL));   // ld r5
        rows.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 1, 0, 1, 0, 0, 1, NOFWD)); // load-use + branch
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ALL));   // r6 was dropped
        rows.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 1, 0, 0, 1, ALL));   // plain flush
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ALL));   // r9 was dropped
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clock);
            got = sample(0);
            exp = expQ.pop_front();
            m = maskQ.pop_front();
            checks++;
            if ((got & m) !== (exp & m)) begin errors++; $display("FAIL flush[%0d] got=%h exp=%h mask=%h", i, got, exp, m); end
            else $display("ok   flush[%0d] got=%h", i, got);
            @(posedge clock);
            #1;
        end
        checks++;
        if (ifA.stall_cycles !== 16'd0) begin errors++; $display("FAIL flush_cnt got=%0d exp=0", ifA.stall_cycles); end
        else $display("ok   flush_cnt got=0");
    endtask

    task automatic test_saturate();
        logic [3:0] want;
        for (int r = 0; r < 5; r++) begin
            apply(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, ALL));
            @(posedge clock);
            #1;
            apply(mk(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, ALL));
            repeat (5) @(posedge clock);
            #1;
            want = (r == 2) ? 4'd12 : 4'd15;
            if (r >= 2) begin
                checks++;
                if (ifB.stall_cycles !== want) begin errors++; $display("FAIL saturate[%0d] got=%0d exp=%0d", r, ifB.stall_cycles, want); end
                else $display("ok   saturate[%0d] got=%0d", r, ifB.stall_cycles);
            end
        end
    endtask

    task automatic test_clear_and_reset();
        apply(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, ALL));
        @(posedge clock);
        #1;
        apply(mk(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, ALL));
        setClr(1'b1);
        @(negedge clock);
        checks++;
        if (ifB.stall !== 1'b1) begin errors++; $display("FAIL clr_stall got=%b exp=1", ifB.stall); end
        else $display("ok   clr_stall got=1");
        @(posedge clock);
        #1;
        setClr(1'b0);
        @(negedge clock);
        checks++;
        if (ifB.stall_cycles !== 4'd0) begin errors++; $display("FAIL clr_cnt got=%0d exp=0", ifB.stall_cycles); end
        else $display("ok   clr_cnt got=0");
        @(posedge clock);
        #1;
        @(negedge clock);
        checks++;
        if (ifB.stall_cycles !== 4'd1 || ifB.stall !== 1'b1) begin
            errors++; $display("FAIL clr_restart cnt=%0d stall=%b exp cnt=1 stall=1", ifB.stall_cycles, ifB.stall);
        end else $display("ok   clr_restart cnt=1 stall=1");
        #2 reset = 1'b0;
        #1;
        checks++;
        if (ifB.stall !== 1'b0 || ifB.bubble_ex !== 1'b0 || ifB.inflight_cnt !== 3'd0 || ifB.stall_cycles !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_stall stall=%b bubble=%b infl=%0d cnt=%0d exp all 0",
                     ifB.stall, ifB.bubble_ex, ifB.inflight_cnt, ifB.stall_cycles);
        end else $display("ok   reset_mid_stall all 0");
        @(negedge clock);
        #2 reset = 1'b1;
    endtask

    initial begin
        test_reset();
        idle(4, 1'b1);
        test_forward();
        idle(4, 1'b1);
        test_load_use();
        idle(4, 1'b1);
        test_interlock();
        idle(4, 1'b1);
        test_flush();
        idle(4, 1'b1);
        test_saturate();
        test_clear_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
